// File: rtl/i2c_multi_target_responder.sv
// Multi-address I2C target: filtered SCL/SDA sampling, address match over programmable slots
// plus general call, and RX/TX byte FIFOs with valid/ready handshakes.
module i2c_multi_target_responder #(
  parameter int unsigned NUM_ADDR      = 2,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned FILTER_LEN    = 3,
  parameter logic [7:0]  TX_EMPTY_BYTE = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  input  logic [7*NUM_ADDR-1:0] cfg_addr_i,
  input  logic [NUM_ADDR-1:0]   cfg_addr_en_i,
  input  logic                  gc_en_i,
  output logic [7:0]            rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [7:0]            tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [2:0]            match_idx_o,
  output logic                  busy_o,
  output logic [2:0]            evt_o,
  output logic                  rx_ovf_o,
  output logic                  tx_unf_o
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  // Input conditioning
  logic [1:0]     scl_sync_q, sda_sync_q;
  logic [FCW-1:0] scl_cnt_q, sda_cnt_q;
  logic           scl_f_q, sda_f_q, scl_p_q, sda_p_q;

  // Protocol FSM
  state_e     state_q;
  logic [3:0] bitcnt_q;
  logic [6:0] shift_q;
  logic       rw_q, ack_q, sda_q, busy_q, ovf_q, unf_q;
  logic [2:0] match_q, evt_q;

  // FIFOs
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [AW:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic [AW:0] rx_wr_d, rx_rd_d, tx_wr_d, tx_rd_d;

  logic       scl_rise, scl_fall, start_det, stop_det, no_cond;
  logic [7:0] rx_byte, load_byte;
  logic       slot_hit, gc_hit;
  logic [2:0] slot_idx;
  logic       rx_empty, rx_full, tx_empty, tx_full;
  logic       rx_push, rx_pop, rx_nack, tx_push, tx_pop, tx_load;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      // The filtered value follows only after FILTER_LEN consecutive differing samples
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FCW'(FILTER_LEN - 1)) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + FCW'(1);
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FCW'(FILTER_LEN - 1)) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + FCW'(1);
      end
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & ~sda_p_q & sda_f_q;
  assign no_cond   = ~start_det & ~stop_det;
  assign rx_byte   = {shift_q, sda_f_q};

  // Address 0 is reserved for general call, so slots never claim it
  always_comb begin
    slot_hit = 1'b0;
    slot_idx = '0;
    for (int unsigned k = 0; k < NUM_ADDR; k++) begin
      if (!slot_hit && cfg_addr_en_i[k] && (rx_byte[7:1] != 7'd0) &&
          (cfg_addr_i[7*k +: 7] == rx_byte[7:1])) begin
        slot_hit = 1'b1;
        slot_idx = 3'(k);
      end
    end
  end

  assign gc_hit = gc_en_i & (rx_byte[7:1] == 7'd0) & ~rx_byte[0];

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);

  assign rx_pop  = rx_ready_i & ~rx_empty;
  assign rx_push = no_cond & (state_q == WR_DATA) & scl_rise & (bitcnt_q == 4'd7) &
                   (~rx_full | rx_pop);
  assign rx_nack = no_cond & (state_q == WR_DATA) & scl_rise & (bitcnt_q == 4'd7) &
                   rx_full & ~rx_pop;
  assign tx_load = no_cond & scl_fall & (bitcnt_q == 4'd9) &
                   (((state_q == ADDR_ACK) & rw_q) | (state_q == RD_ACK));
  assign tx_pop  = tx_load & ~tx_empty;
  assign tx_push = tx_valid_i & (~tx_full | tx_pop);

  assign load_byte = tx_empty ? TX_EMPTY_BYTE : tx_mem_q[tx_rd_q[AW-1:0]];

  always_comb begin
    rx_wr_d = rx_push ? rx_wr_q + (AW+1)'(1) : rx_wr_q;
    rx_rd_d = rx_pop  ? rx_rd_q + (AW+1)'(1) : rx_rd_q;
    tx_wr_d = tx_push ? tx_wr_q + (AW+1)'(1) : tx_wr_q;
    tx_rd_d = tx_pop  ? tx_rd_q + (AW+1)'(1) : tx_rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= rx_byte;
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= tx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      rw_q     <= 1'b0;
      ack_q    <= 1'b0;
      sda_q    <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      match_q  <= '0;
      evt_q    <= '0;
    end else begin
      evt_q <= '0;
      unf_q <= 1'b0;
      if (start_det) begin
        evt_q    <= busy_q ? 3'b010 : 3'b001;
        busy_q   <= 1'b1;
        sda_q    <= 1'b1;
        bitcnt_q <= '0;
        state_q  <= ADDR;
      end else if (stop_det) begin
        evt_q    <= 3'b100;
        busy_q   <= 1'b0;
        sda_q    <= 1'b1;
        bitcnt_q <= '0;
        state_q  <= IDLE;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q  <= rx_byte[6:0];
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7) begin
                rw_q <= rx_byte[0];
                if (slot_hit || gc_hit) begin
                  match_q <= gc_hit ? 3'd7 : slot_idx;
                  state_q <= ADDR_ACK;
                end else begin
                  state_q <= WAIT_STOP;
                end
              end
            end
          end
          // bitcnt 8 -> drive ACK on the 8th fall; 9 -> 9th rise seen, hand off on the next fall
          ADDR_ACK: begin
            if (scl_rise) begin
              bitcnt_q <= 4'd9;
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd9) begin
                bitcnt_q <= '0;
                if (rw_q) begin
                  shift_q <= load_byte[6:0];
                  sda_q   <= load_byte[7];
                  unf_q   <= tx_empty;
                  state_q <= RD_DATA;
                end else begin
                  sda_q   <= 1'b1;
                  state_q <= WR_DATA;
                end
              end else begin
                sda_q <= 1'b0;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift_q  <= rx_byte[6:0];
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7) begin
                ack_q   <= ~rx_nack;
                ovf_q   <= ovf_q | rx_nack;
                state_q <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_rise) begin
              bitcnt_q <= 4'd9;
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd9) begin
                sda_q    <= 1'b1;
                bitcnt_q <= '0;
                state_q  <= WR_DATA;
              end else begin
                sda_q <= ~ack_q;
              end
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                sda_q   <= 1'b1;
                state_q <= RD_ACK;
              end else begin
                sda_q   <= shift_q[6];
                shift_q <= {shift_q[5:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_f_q) state_q <= WAIT_STOP;
              else         bitcnt_q <= 4'd9;
            end else if (scl_fall && bitcnt_q == 4'd9) begin
              shift_q  <= load_byte[6:0];
              sda_q    <= load_byte[7];
              unf_q    <= tx_empty;
              bitcnt_q <= '0;
              state_q  <= RD_DATA;
            end
          end
          default: begin
            sda_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sda_o       = sda_q;
  assign busy_o      = busy_q;
  assign evt_o       = evt_q;
  assign match_idx_o = match_q;
  assign rx_ovf_o    = ovf_q;
  assign tx_unf_o    = unf_q;
  assign rx_valid_o  = ~rx_empty;
  assign tx_ready_o  = ~tx_full;
  assign rx_data_o   = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[AW-1:0]];

endmodule

// File: tb/tb_i2c_multi_target_responder.sv
// Bench for i2c_multi_target_responder: bit-banged I2C master against a queue-based target model.
module tb_i2c_multi_target_responder;

  localparam int unsigned NA    = 2;
  localparam int unsigned DEPTH = 16;
  localparam int          Q     = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, scl_m, sda_m, gc_en, rx_ready, tx_valid;
  logic [7*NA-1:0]   cfg_addr;
  logic [NA-1:0]     cfg_en;
  logic [7:0]        tx_data;
  logic              sda_o, rx_valid, tx_ready, busy, rx_ovf, tx_unf;
  logic [7:0]        rx_data;
  logic [2:0]        match_idx, evt;
  wire               sda_bus;

  assign sda_bus = sda_m & sda_o;

  i2c_multi_target_responder #(
    .NUM_ADDR(NA), .FIFO_DEPTH(DEPTH), .FILTER_LEN(3), .TX_EMPTY_BYTE(8'hFF)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o),
    .cfg_addr_i(cfg_addr), .cfg_addr_en_i(cfg_en), .gc_en_i(gc_en),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .match_idx_o(match_idx), .busy_o(busy), .evt_o(evt),
    .rx_ovf_o(rx_ovf), .tx_unf_o(tx_unf)
  );

  int checks = 0;
  int failures = 0;

  // Observed pulse counts
  int n_start = 0, n_restart = 0, n_stop = 0, n_unf = 0;
  always @(negedge clk) begin
    if (evt[0]) n_start++;
    if (evt[1]) n_restart++;
    if (evt[2]) n_stop++;
    if (tx_unf) n_unf++;
  end

  // Reference model
  logic [6:0] slot_m [NA];
  logic [7:0] rxq[$], txq[$], payload[$];
  int         m_start = 0, m_restart = 0, m_stop = 0, m_unf = 0;
  logic       m_busy = 1'b0, m_ovf = 1'b0;

  assign cfg_addr = {slot_m[1], slot_m[0]};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ack_addr(input logic [6:0] a, input logic rw, output logic [2:0] idx);
    idx = 3'd7;
    if (a == 7'd0) return gc_en && !rw;
    for (int k = 0; k < NA; k++)
      if (cfg_en[k] && slot_m[k] == a) begin
        idx = 3'(k);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic bus_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (m_busy) m_restart++; else m_start++;
    m_busy = 1'b1;
    sda_m = 1'b1; bus_wait(Q);
    scl_m = 1'b1; bus_wait(2*Q);
    sda_m = 1'b0; bus_wait(2*Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    m_stop++;
    m_busy = 1'b0;
    sda_m = 1'b0; bus_wait(Q);
    scl_m = 1'b1; bus_wait(2*Q);
    sda_m = 1'b1; bus_wait(2*Q);
  endtask

  task automatic write_bit(input logic b);
    bus_wait(Q); sda_m = b; bus_wait(Q);
    scl_m = 1'b1; bus_wait(2*Q);
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; bus_wait(2*Q);
    scl_m = 1'b1; bus_wait(Q);
    b = sda_bus; bus_wait(Q);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(r);
    ack = ~r;
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) read_bit(b[i]);
  endtask

  task automatic do_write(input logic [6:0] a);
    logic ack, exp;
    logic [2:0] idx;
    i2c_start();
    exp = m_ack_addr(a, 1'b0, idx);
    write_byte({a, 1'b0}, ack);
    check("addr_ack_wr", ack, exp);
    if (exp) begin
      check("match_idx_wr", match_idx, idx);
      check("busy_in_xfer", busy, 1);
      foreach (payload[i]) begin
        exp = (rxq.size() < DEPTH);
        if (exp) rxq.push_back(payload[i]); else m_ovf = 1'b1;
        write_byte(payload[i], ack);
        check("data_ack", ack, exp);
      end
    end
  endtask

  task automatic do_read(input logic [6:0] a, input int n);
    logic ack, exp;
    logic [2:0] idx;
    logic [7:0] b, eb;
    i2c_start();
    exp = m_ack_addr(a, 1'b1, idx);
    write_byte({a, 1'b1}, ack);
    check("addr_ack_rd", ack, exp);
    if (exp) begin
      check("match_idx_rd", match_idx, idx);
      for (int k = 0; k < n; k++) begin
        if (txq.size() > 0) eb = txq.pop_front();
        else begin eb = 8'hFF; m_unf++; end
        read_byte(b);
        check("rd_byte", b, eb);
        write_bit(k == n - 1);
      end
      check("rd_release", sda_o, 1);
    end
  endtask

  task automatic check_counts();
    bus_wait(Q);
    check("evt_start", n_start, m_start);
    check("evt_restart", n_restart, m_restart);
    check("evt_stop", n_stop, m_stop);
    check("tx_unf_pulses", n_unf, m_unf);
    check("rx_ovf", rx_ovf, m_ovf);
    check("busy", busy, m_busy);
  endtask

  task automatic drain_rx();
    logic [7:0] e;
    while (rxq.size() > 0) begin
      e = rxq.pop_front();
      check("rx_valid", rx_valid, 1);
      check("rx_data", rx_data, e);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    check("rx_empty", rx_valid, 0);
  endtask

  task automatic push_tx(input logic [7:0] b);
    logic exp;
    exp = (txq.size() < DEPTH);
    check("tx_ready", tx_ready, exp);
    tx_data = b; tx_valid = 1'b1;
    if (exp) txq.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic ack;
    logic [6:0] a;
    int n;
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; gc_en = 1'b1;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
    slot_m[0] = 7'h22;
    slot_m[1] = 7'($urandom_range(1, 127));
    if (slot_m[1] == 7'h22 || slot_m[1] == 7'h28) slot_m[1] = 7'h31;
    cfg_en = 2'b11;
    bus_wait(5);
    check("rst_sda", sda_o, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_evt", evt, 0);
    check("rst_match", match_idx, 0);
    check("rst_ovf", rx_ovf, 0);
    check("rst_unf", tx_unf, 0);
    rst_n = 1'b1;
    bus_wait(Q);

    payload = '{8'hA1, 8'h5C};
    do_write(7'h22); i2c_stop(); check_counts(); drain_rx();

    push_tx(8'h3C); push_tx(8'hC3);
    do_read(7'h22, 2); i2c_stop(); check_counts();

    do_read(7'h22, 3); i2c_stop(); check_counts();

    payload.delete();
    for (int i = 0; i <= DEPTH; i++) payload.push_back(8'($urandom));
    do_write(7'h22); i2c_stop(); check_counts(); drain_rx();

    push_tx(8'($urandom));
    payload = '{8'h44, 8'h11};
    do_write(7'h22); do_read(7'h22, 1); i2c_stop(); check_counts(); drain_rx();

    payload = '{8'($urandom)};
    do_write(7'h28); i2c_stop(); check_counts(); drain_rx();

    payload = '{8'($urandom)};
    do_write(7'h00); do_read(7'h00, 1); i2c_stop(); check_counts(); drain_rx();

    for (int it = 0; it < 8; it++) begin
      cfg_en = 2'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) push_tx(8'($urandom));
      repeat ($urandom_range(1, 2)) begin
        case ($urandom_range(0, 3))
          0: a = 7'h22;
          1: a = slot_m[1];
          2: a = 7'h00;
          default: a = 7'($urandom);
        endcase
        n = $urandom_range(1, 3);
        if ($urandom_range(0, 1) == 1) begin
          payload.delete();
          repeat (n) payload.push_back(8'($urandom));
          do_write(a);
        end else begin
          do_read(a, n);
        end
      end
      i2c_stop(); check_counts(); drain_rx();
    end
    cfg_en = 2'b11;

    // Reset while the target is pulling SDA low mid-read
    payload = '{8'h77};
    do_write(7'h22);
    push_tx(8'h00); push_tx(8'h5A);
    i2c_start();
    write_byte({7'h22, 1'b1}, ack);
    check("mid_rd_addr_ack", ack, 1);
    bus_wait(Q);
    check("mid_rd_sda_low", sda_o, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("post_rst_sda", sda_o, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_rx_valid", rx_valid, 0);
    check("post_rst_tx_ready", tx_ready, 1);
    check("post_rst_ovf", rx_ovf, 0);
    rst_n = 1'b1;
    rxq.delete(); txq.delete();
    m_busy = 1'b0; m_ovf = 1'b0;
    void'(txq.size());
    bus_wait(Q);
    i2c_stop(); check_counts();
    do_read(7'h22, 1); i2c_stop(); check_counts(); drain_rx();

    // One-clock SDA glitch while idle must not register as START
    @(negedge clk); sda_m = 1'b0;
    @(negedge clk); sda_m = 1'b1;
    bus_wait(2*Q);
    check_counts();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
